relu_maxpool: RTL

// - Downstream of the 3x3 convolution stage: consumes its 16-bit pxl_out/valid stream, optional ReLU, 2x2 stride-2 max-pool.
// - One pooled pixel per 2x2 window of valid conv outputs, raster order; feeds next CNN layer / readout.
// - Line buffer holds one row of horizontal pair-maxima; no back-pressure (source never stalls on us).

---
 rtl/relu_maxpool.sv | 167 ++++++++++++++++
 1 files changed

// File: rtl/relu_maxpool.sv
// relu_maxpool
//   Optional ReLU followed by a 2x2 stride-2 max-pool over the raster-order
//   pixel stream of the 3x3 convolution stage. A one-row line buffer keeps
//   the horizontal pair-maxima of each even row. Those values are combined
//   with the pair-maxima of the following odd row to produce one pooled pixel
//   per 2x2 window. The block applies no back-pressure.
//
//   Build option: define RELU_MAXPOOL_RELU_EN to clamp negative inputs to 0
//   before pooling. When it is left undefined, the block is a pure signed
//   max-pool. Timing and counters are the same in both builds.
//
// Parameters
//   IN_W  valid conv pixels per row (odd -> last column dropped), <= 255
//   IN_H  valid conv rows per frame (odd -> last row dropped), <= 255
//   DW    pixel width, two's complement
//
// Ports
//   clk         rising-edge clock
//   reset       synchronous active-low reset (0 = reset)
//   pxl_in      conv output pixel, signed
//   valid_in    pxl_in qualifier; only valid beats advance state
//   pool_out    pooled pixel, registered, holds between pulses
//   pool_valid  1-cycle pulse per pooled pixel
//   pool_col    output column index of pool_out
//   pool_row    output row index of pool_out
//   frame_done  1-cycle pulse after the last input beat of a frame
module relu_maxpool #(
  parameter int IN_W = 4,
  parameter int IN_H = 4,
  parameter int DW   = 16
) (
  input  logic          clk,
  input  logic          reset,
  input  logic [DW-1:0] pxl_in,
  input  logic          valid_in,
  output logic [DW-1:0] pool_out,
  output logic          pool_valid,
  output logic [7:0]    pool_col,
  output logic [7:0]    pool_row,
  output logic          frame_done
);

  localparam int PW = (IN_W / 2 > 0) ? IN_W / 2 : 1;
  localparam logic [7:0] COL_LAST = 8'(IN_W - 1);
  localparam logic [7:0] ROW_LAST = 8'(IN_H - 1);
  // Columns/rows at or beyond these limits are the odd-dimension leftovers.
  localparam logic [7:0] COL_LIM  = 8'(2 * (IN_W / 2));
  localparam logic [7:0] ROW_LIM  = 8'(2 * (IN_H / 2));

  function automatic logic signed [DW-1:0] smax(input logic signed [DW-1:0] a,
                                                input logic signed [DW-1:0] b);
    return (a > b) ? a : b;
  endfunction

  logic [7:0]           col_q, col_d;
  logic [7:0]           row_q, row_d;
  logic signed [DW-1:0] h_max_q, h_max_d;
  logic signed [DW-1:0] linebuf_q [PW];
  logic signed [DW-1:0] linebuf_d [PW];
  logic signed [DW-1:0] pool_out_q, pool_out_d;
  logic                 pool_valid_q, pool_valid_d;
  logic [7:0]           pool_col_q, pool_col_d;
  logic [7:0]           pool_row_q, pool_row_d;
  logic                 frame_done_q, frame_done_d;

  logic signed [DW-1:0] x;
  logic signed [DW-1:0] lb_rd;
  logic signed [DW-1:0] pair_max;
  logic signed [DW-1:0] win_max;
  logic [7:0]           col_half;

  always_comb begin
`ifdef RELU_MAXPOOL_RELU_EN
    x = pxl_in[DW-1] ? '0 : $signed(pxl_in);
`else
    x = $signed(pxl_in);
`endif
  end

  assign col_half = {1'b0, col_q[7:1]};

  always_comb begin
    lb_rd = '0;
    for (int i = 0; i < PW; i++) begin
      if (col_half == 8'(i)) lb_rd = linebuf_q[i];
    end
  end

  assign pair_max = smax(h_max_q, x);
  assign win_max  = smax(lb_rd, pair_max);

  always_comb begin
    col_d        = col_q;
    row_d        = row_q;
    h_max_d      = h_max_q;
    linebuf_d    = linebuf_q;
    pool_out_d   = pool_out_q;
    pool_valid_d = 1'b0;
    pool_col_d   = pool_col_q;
    pool_row_d   = pool_row_q;
    frame_done_d = 1'b0;

    if (valid_in) begin
      if (col_q < COL_LIM && row_q < ROW_LIM) begin
        if (!col_q[0]) begin
          h_max_d = x;
        end else if (!row_q[0]) begin
          for (int i = 0; i < PW; i++) begin
            if (col_half == 8'(i)) linebuf_d[i] = pair_max;
          end
        end else begin
          pool_out_d   = win_max;
          pool_valid_d = 1'b1;
          pool_col_d   = col_half;
          pool_row_d   = {1'b0, row_q[7:1]};
        end
      end

      if (col_q == COL_LAST) begin
        col_d = '0;
        if (row_q == ROW_LAST) begin
          row_d        = '0;
          frame_done_d = 1'b1;
        end else begin
          row_d = row_q + 8'd1;
        end
      end else begin
        col_d = col_q + 8'd1;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      col_q        <= '0;
      row_q        <= '0;
      h_max_q      <= '0;
      pool_out_q   <= '0;
      pool_valid_q <= 1'b0;
      pool_col_q   <= '0;
      pool_row_q   <= '0;
      frame_done_q <= 1'b0;
    end else begin
      col_q        <= col_d;
      row_q        <= row_d;
      h_max_q      <= h_max_d;
      pool_out_q   <= pool_out_d;
      pool_valid_q <= pool_valid_d;
      pool_col_q   <= pool_col_d;
      pool_row_q   <= pool_row_d;
      frame_done_q <= frame_done_d;
    end
  end

  // Every entry is rewritten in an even row before an odd row reads it,
  // so the line buffer needs no reset.
  always_ff @(posedge clk) begin
    linebuf_q <= linebuf_d;
  end

  assign pool_out   = pool_out_q;
  assign pool_valid = pool_valid_q;
  assign pool_col   = pool_col_q;
  assign pool_row   = pool_row_q;
  assign frame_done = frame_done_q;

endmodule
